// File: rtl/des_key_sched_dec_if.sv
// Subkey stream bundle between the DES key scheduler (slave side) and its
// consumer / load requester (master side).
interface des_key_sched_dec_if;
    // Handshake: a subkey transfers on every rising edge where subkey_valid
    // and subkey_ready are both high; while valid is high and ready is low,
    // subkey and round_idx hold steady. start is a one-cycle request that is
    // only taken while the scheduler is idle.
    logic        start;
    logic [63:0] key_in;
    logic        subkey_ready;
    logic        subkey_valid;
    logic [47:0] subkey;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    modport master (
        output start, key_in, subkey_ready,
        input  subkey_valid, subkey, round_idx, busy, done
    );

    modport slave (
        input  start, key_in, subkey_ready,
        output subkey_valid, subkey, round_idx, busy, done
    );
endinterface

// File: rtl/des_key_sched_dec.sv
// Sequential DES subkey generator: PC-1 on load, then one PC-2 subkey per
// accepted handshake, K16..K1 with right rotations (MODE=1) or K1..K16 (MODE=0).
module des_key_sched_dec #(
    parameter bit MODE = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    des_key_sched_dec_if.slave        i_sched,
    output logic [1:0]                o_dbg_state,
    output logic                      o_dbg_par_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // FIPS bit numbering: table entry n selects FIPS bit n (bit 1 = MSB).
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Rotation applied after accept k; the left schedule from round 2 on and the
    // right schedule from K16 down are the same list. Entry 15 is never used.
    localparam logic [1:0] AMT [16] = '{
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0
    };

    state_t      r_state;
    state_t      w_state_nxt;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [27:0] w_c_nxt;
    logic [27:0] w_d_nxt;
    logic [3:0]  r_count;
    logic [3:0]  w_count_nxt;
    logic        r_par_err;
    logic        w_par_err_nxt;

    logic [55:0] w_pc1;
    logic [55:0] w_cd;
    logic [47:0] w_pc2;
    logic [7:0]  w_byte_bad;
    logic        w_accept;
    logic        w_valid;

    function automatic logic [27:0] rot28(input logic [27:0] v,
                                          input logic [1:0]  amt,
                                          input logic        left);
        logic [27:0] r;
        r = v;
        if (left) begin
            if (amt == 2'd1) r = {v[26:0], v[27]};
            else if (amt == 2'd2) r = {v[25:0], v[27:26]};
        end else begin
            if (amt == 2'd1) r = {v[0], v[27:1]};
            else if (amt == 2'd2) r = {v[1:0], v[27:2]};
        end
        return r;
    endfunction

    genvar g;
    generate
        for (g = 0; g < 56; g++) begin : g_pc1
            assign w_pc1[55-g] = i_sched.key_in[64-PC1[g]];
        end
        for (g = 0; g < 48; g++) begin : g_pc2
            assign w_pc2[47-g] = w_cd[56-PC2[g]];
        end
        // Parity bits do not feed the schedule; a byte with even parity is
        // only flagged for debug.
        for (g = 0; g < 8; g++) begin : g_par
            assign w_byte_bad[g] = ~^i_sched.key_in[8*g+7 : 8*g];
        end
    endgenerate

    assign w_cd     = {r_c, r_d};
    assign w_valid  = (r_state == S_RUN);
    assign w_accept = w_valid & i_sched.subkey_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_c       <= 28'd0;
            r_d       <= 28'd0;
            r_count   <= 4'd0;
            r_par_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_c       <= w_c_nxt;
            r_d       <= w_d_nxt;
            r_count   <= w_count_nxt;
            r_par_err <= w_par_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_c_nxt       = r_c;
        w_d_nxt       = r_d;
        w_count_nxt   = r_count;
        w_par_err_nxt = r_par_err;
        case (r_state)
            S_IDLE: begin
                if (i_sched.start) begin
                    w_state_nxt   = S_RUN;
                    w_count_nxt   = 4'd0;
                    w_par_err_nxt = |w_byte_bad;
                    // Decrypt starts from C0/D0 (28 total left shifts = identity).
                    if (MODE) begin
                        w_c_nxt = w_pc1[55:28];
                        w_d_nxt = w_pc1[27:0];
                    end else begin
                        w_c_nxt = rot28(w_pc1[55:28], 2'd1, 1'b1);
                        w_d_nxt = rot28(w_pc1[27:0], 2'd1, 1'b1);
                    end
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    if (r_count == 4'd15) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_count_nxt = r_count + 4'd1;
                        w_c_nxt     = rot28(r_c, AMT[r_count], !MODE);
                        w_d_nxt     = rot28(r_d, AMT[r_count], !MODE);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign i_sched.subkey_valid = w_valid;
    assign i_sched.subkey       = w_pc2;
    assign i_sched.round_idx    = !w_valid ? 4'd0 : (MODE ? (4'd15 - r_count) : r_count);
    assign i_sched.busy         = w_valid;
    assign i_sched.done         = (r_state == S_DONE);
    assign o_dbg_state          = r_state;
    assign o_dbg_par_err        = r_par_err;

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Directed bench for des_key_sched_dec: one decrypt-order and one encrypt-order
// instance, checked against the published subkeys of key 133457799BBCDFF1.
module tb_des_key_sched_dec;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_key_sched_dec_if bus_dec ();
    des_key_sched_dec_if bus_enc ();

    logic [1:0] st_dec;
    logic [1:0] st_enc;
    logic       pe_dec;
    logic       pe_enc;

    des_key_sched_dec #(.MODE(1'b1)) dut_dec (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sched       (bus_dec),
        .o_dbg_state   (st_dec),
        .o_dbg_par_err (pe_dec)
    );

    des_key_sched_dec #(.MODE(1'b0)) dut_enc (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sched       (bus_enc),
        .o_dbg_state   (st_enc),
        .o_dbg_par_err (pe_enc)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

    // ktab[i] = K(i+1) for KEY_A
    logic [47:0] ktab [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decrypt instance at position n presents K(16-n) with round_idx 15-n.
    task automatic chk_dec(input int n, input string tag);
        chk({tag, " dec valid"}, 64'(bus_dec.subkey_valid), 64'd1);
        chk({tag, " dec idx"}, 64'(bus_dec.round_idx), 64'(15 - n));
        chk({tag, " dec subkey"}, 64'(bus_dec.subkey), 64'(ktab[15-n]));
    endtask

    task automatic chk_enc(input int n, input string tag);
        chk({tag, " enc valid"}, 64'(bus_enc.subkey_valid), 64'd1);
        chk({tag, " enc idx"}, 64'(bus_enc.round_idx), 64'(n));
        chk({tag, " enc subkey"}, 64'(bus_enc.subkey), 64'(ktab[n]));
    endtask

    task automatic chk_dec_reset_outputs(input string tag);
        chk({tag, " valid"}, 64'(bus_dec.subkey_valid), 64'd0);
        chk({tag, " busy"}, 64'(bus_dec.busy), 64'd0);
        chk({tag, " done"}, 64'(bus_dec.done), 64'd0);
        chk({tag, " subkey"}, 64'(bus_dec.subkey), 64'd0);
        chk({tag, " idx"}, 64'(bus_dec.round_idx), 64'd0);
    endtask

    initial begin
        int n;
        int cyc;
        logic rdy;

        rst = 1'b1;
        bus_dec.start = 1'b0;
        bus_dec.key_in = 64'd0;
        bus_dec.subkey_ready = 1'b0;
        bus_enc.start = 1'b0;
        bus_enc.key_in = 64'd0;
        bus_enc.subkey_ready = 1'b0;

        // T1: reset
        tick();
        tick();
        chk_dec_reset_outputs("t1");
        chk("t1 enc valid", 64'(bus_enc.subkey_valid), 64'd0);
        chk("t1 enc idx", 64'(bus_enc.round_idx), 64'd0);
        chk("t1 enc subkey", 64'(bus_enc.subkey), 64'd0);
        rst = 1'b0;

        // T2/T3: both orders back-to-back with ready held high
        bus_dec.key_in = KEY_A;
        bus_enc.key_in = KEY_A;
        bus_dec.start = 1'b1;
        bus_enc.start = 1'b1;
        bus_dec.subkey_ready = 1'b1;
        bus_enc.subkey_ready = 1'b1;
        tick();
        bus_dec.start = 1'b0;
        bus_enc.start = 1'b0;
        chk("t2 busy", 64'(bus_dec.busy), 64'd1);
        chk("t2 state", 64'(st_dec), 64'd1);
        chk("t2 parity flag", 64'(pe_dec), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk_dec(i, "t2");
            chk_enc(i, "t3");
            tick();
        end
        chk("t2 done", 64'(bus_dec.done), 64'd1);
        chk("t2 valid after last", 64'(bus_dec.subkey_valid), 64'd0);
        chk("t2 busy after last", 64'(bus_dec.busy), 64'd0);
        chk("t3 done", 64'(bus_enc.done), 64'd1);
        chk("t3 valid after last", 64'(bus_enc.subkey_valid), 64'd0);
        tick();
        chk("t2 done pulse width", 64'(bus_dec.done), 64'd0);
        chk("t2 back to idle", 64'(st_dec), 64'd0);

        // T4: random backpressure on the decrypt instance
        bus_dec.key_in = KEY_A;
        bus_dec.start = 1'b1;
        bus_dec.subkey_ready = 1'b0;
        tick();
        bus_dec.start = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 16 && cyc < 400) begin
            chk_dec(n, "t4");
            rdy = 1'($urandom_range(0, 1));
            bus_dec.subkey_ready = rdy;
            tick();
            if (rdy) n++;
            cyc++;
        end
        chk("t4 accept count", 64'(n), 64'd16);
        chk("t4 done", 64'(bus_dec.done), 64'd1);
        bus_dec.subkey_ready = 1'b1;
        tick();

        // T5: start with another key mid-run and in the DONE cycle is ignored
        bus_dec.key_in = KEY_A;
        bus_dec.start = 1'b1;
        tick();
        bus_dec.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_dec(i, "t5");
            bus_dec.start = (i == 7);
            if (i >= 7) bus_dec.key_in = KEY_B;
            tick();
        end
        bus_dec.start = 1'b0;
        chk("t5 done", 64'(bus_dec.done), 64'd1);
        bus_dec.start = 1'b1;
        tick();
        chk("t5 start in done ignored valid", 64'(bus_dec.subkey_valid), 64'd0);
        chk("t5 start in done ignored state", 64'(st_dec), 64'd0);
        bus_dec.start = 1'b0;
        tick();
        chk("t5 still idle", 64'(bus_dec.subkey_valid), 64'd0);

        // T6: reset mid-run at idx 7, then a full run
        bus_dec.key_in = KEY_A;
        bus_dec.start = 1'b1;
        tick();
        bus_dec.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_dec(i, "t6 pre");
            tick();
        end
        chk_dec(8, "t6 at reset");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_dec_reset_outputs("t6 reset");
        chk("t6 state", 64'(st_dec), 64'd0);
        bus_dec.start = 1'b1;
        tick();
        bus_dec.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_dec(i, "t6 run");
            tick();
        end
        chk("t6 done", 64'(bus_dec.done), 64'd1);
        chk("t6 valid after last", 64'(bus_dec.subkey_valid), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
